// File: rtl/writeback_arbiter_pkg.sv
// Shared encodings and types for the writeback arbiter: enable levels,
// write-source select codes and the buffered LSU result record.
package writeback_arbiter_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int RD_W    = 5;
  localparam int DATA_W  = 32;
  localparam int ENTRY_W = RD_W + DATA_W;

  localparam logic [1:0] WB_SRC_NONE = 2'd0;
  localparam logic [1:0] WB_SRC_ALU  = 2'd1;
  localparam logic [1:0] WB_SRC_LSU  = 2'd2;

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/writeback_arbiter_fifo.sv
// Small circular FIFO holding LSU results (rd + data) awaiting a free write slot.
// Pointers wrap naturally because DEPTH is a power of two.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and buffered LSU results onto the single register-file write port,
// with a starvation guard for the LSU stream and a bypass onto decode read data.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic        reg_we,
  output logic [4:0]  w_addr,
  output logic [31:0] w_data,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_raw,
  input  logic [31:0] rs2_raw,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SW    = $clog2(STARVE_MAX + 1);

  wb_entry_t        fifo_head;
  wb_entry_t        lsu_entry;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic             drain;
  logic             alu_write;
  logic [1:0]       sel;
  logic [SW-1:0]    starve_cnt_reg;
  logic [SW-1:0]    starve_cnt_next;
  logic             reg_we_reg;
  logic [4:0]       w_addr_reg;
  logic [31:0]      w_data_reg;

  assign lsu_entry = '{rd: lsu_rd, data: lsu_data};
  assign lsu_ready = (fifo_count < CNT_W'(DEPTH));
  // rd=0 results are acknowledged but never buffered.
  assign fifo_push = lsu_valid && !fifo_full && (lsu_rd != 5'd0);

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (lsu_entry),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign drain     = !fifo_empty && (starve_cnt_reg == SW'(STARVE_MAX));
  assign alu_ready = !drain;
  assign alu_write = !drain && alu_valid && (alu_rd != 5'd0);
  assign fifo_pop  = !fifo_empty && !alu_write;

  always_comb begin
    sel = WB_SRC_NONE;
    if (alu_write)        sel = WB_SRC_ALU;
    else if (!fifo_empty) sel = WB_SRC_LSU;
  end

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (fifo_empty || fifo_pop)               starve_cnt_next = '0;
    else if (starve_cnt_reg != SW'(STARVE_MAX)) starve_cnt_next = starve_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_reg <= '0;
      reg_we_reg     <= DISABLE;
      w_addr_reg     <= '0;
      w_data_reg     <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      reg_we_reg     <= (sel != WB_SRC_NONE) ? ENABLE : DISABLE;
      if (sel == WB_SRC_ALU) begin
        w_addr_reg <= alu_rd;
        w_data_reg <= alu_data;
      end else if (sel == WB_SRC_LSU) begin
        w_addr_reg <= fifo_head.rd;
        w_data_reg <= fifo_head.data;
      end
    end
  end

  assign reg_we = reg_we_reg;
  assign w_addr = w_addr_reg;
  assign w_data = w_data_reg;

  assign rs1_data = (reg_we_reg && (w_addr_reg == rs1_addr) && (rs1_addr != 5'd0)) ? w_data_reg : rs1_raw;
  assign rs2_data = (reg_we_reg && (w_addr_reg == rs2_addr) && (rs2_addr != 5'd0)) ? w_data_reg : rs2_raw;

endmodule
